// File: rtl/dmem_io.sv
// -----------------------------------------------------------------------------
// dmem_io
//   Data-side memory and memory-mapped I/O stage for the single-cycle MIPS core.
//   Holds a word-addressed data RAM, an LED register, a synchronised switch
//   input, a 32-bit display register driving a scanned 8-digit 7-segment
//   display, and an optional free-running timer.
//
//   Reads are combinational from addr; writes commit on the rising clock edge.
//
//   Address map:
//     addr[31]=0  RAM, word index addr[$clog2(DMEM_WORDS)+1:2] (upper bits alias)
//     addr[31]=1  MMIO on addr[3:2]: 00 LED, 01 SW (RO), 10 DISP, 11 TIMER
//
//   Optional feature macro: DMEM_IO_TIMER_EN
//     defined   -> MMIO 11 is a loadable 32-bit free-running counter
//     undefined -> MMIO 11 reads 0, writes ignored, no counter logic
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous reset, active-low
//   memwrite   in   1   store strobe from core
//   addr       in   32  byte address (core aluout); addr[1:0] ignored
//   writedata  in   32  store data
//   readdata   out  32  load data, combinational from addr
//   sw         in   16  board switches (asynchronous)
//   led        out  16  LED register
//   an         out  8   digit enables, active-low
//   seg        out  7   segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module dmem_io #(
  parameter int DMEM_WORDS = 64,
  parameter int SCAN_DIV   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int AW = $clog2(DMEM_WORDS);

  // MMIO register offsets on addr[3:2]
  localparam logic [1:0] REG_LED   = 2'b00;
  localparam logic [1:0] REG_SW    = 2'b01;
  localparam logic [1:0] REG_DISP  = 2'b10;
  localparam logic [1:0] REG_TIMER = 2'b11;

  logic [31:0]         mem [DMEM_WORDS];
  logic [AW-1:0]       ram_idx;
  logic                is_mmio;
  logic [1:0]          mmio_sel;
  logic                ram_we;
  logic                led_we;
  logic                disp_we;

  logic [15:0]         led_q;
  logic [31:0]         disp_q;
  logic [15:0]         sw_meta_q;
  logic [15:0]         sw_sync_q;
  logic [SCAN_DIV-1:0] scan_q;
  logic [SCAN_DIV-1:0] scan_d;
  logic [2:0]          digit_idx;
  logic [3:0]          digit_nib;
  logic [7:0]          an_q;
  logic [7:0]          an_d;
  logic [6:0]          seg_q;
  logic [6:0]          seg_d;
  logic [31:0]         timer_rd;

  // Address bits that the decode deliberately ignores (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[30:AW+2], addr[1:0]};

  assign ram_idx  = addr[AW+1:2];
  assign is_mmio  = addr[31];
  assign mmio_sel = addr[3:2];
  assign ram_we   = memwrite & ~is_mmio;
  assign led_we   = memwrite &  is_mmio & (mmio_sel == REG_LED);
  assign disp_we  = memwrite &  is_mmio & (mmio_sel == REG_DISP);

  // Active-low gfedcba hex decode for one display nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // RAM contents survive reset, so this block has no reset term.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= 16'h0;
      disp_q <= 32'h0;
    end else begin
      if (led_we) begin
        led_q <= writedata[15:0];
      end
      if (disp_we) begin
        disp_q <= writedata;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= 16'h0;
      sw_sync_q <= 16'h0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // The top three scan bits pick the digit; an/seg are registered from the
  // current scan value, giving one cycle of latency to the pins.
  assign digit_idx = scan_q[SCAN_DIV-1 -: 3];
  assign digit_nib = disp_q[{digit_idx, 2'b00} +: 4];

  always_comb begin
    scan_d = scan_q + SCAN_DIV'(1);
    an_d   = ~(8'b1 << digit_idx);
    seg_d  = hex7(digit_nib);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q <= '0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
    end else begin
      scan_q <= scan_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

`ifdef DMEM_IO_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] timer_d;
  logic        timer_we;

  assign timer_we = memwrite & is_mmio & (mmio_sel == REG_TIMER);

  // A store loads the counter; counting resumes from the loaded value.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (timer_we) begin
      timer_d = writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= 32'h0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = 32'h0;
`endif

  // Load data shows the stored value before the edge, so a same-cycle
  // store and load of one address returns the old word.
  always_comb begin
    readdata = 32'h0;
    if (!is_mmio) begin
      readdata = mem[ram_idx];
    end else begin
      case (mmio_sel)
        REG_LED:  readdata = {16'h0, led_q};
        REG_SW:   readdata = {16'h0, sw_sync_q};
        REG_DISP: readdata = disp_q;
        REG_TIMER: readdata = timer_rd;
        default:  readdata = 32'h0;
      endcase
    end
  end

  assign led = led_q;
  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_dmem_io.sv
// -----------------------------------------------------------------------------
// tb_dmem_io
//   Directed testbench for dmem_io built with SCAN_DIV=4 so a full display
//   scan takes 16 cycles. Inputs change on the falling edge; outputs are
//   sampled just before and 1 time unit after rising edges.
// -----------------------------------------------------------------------------
module tb_dmem_io;

  localparam int DMEM_WORDS = 64;
  localparam int SCAN_DIV   = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;

  int total;
  int bad;

  dmem_io #(
    .DMEM_WORDS(DMEM_WORDS),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .sw       (sw),
    .led      (led),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected active-low segment pattern for digits 0..7, worked out by hand.
  function automatic logic [6:0] expSeg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'h40;
      1: s = 7'h79;
      2: s = 7'h24;
      3: s = 7'h30;
      4: s = 7'h19;
      5: s = 7'h12;
      6: s = 7'h02;
      default: s = 7'h78;
    endcase
    return s;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    memwrite = 1'b0;
    #1;
    total++;
    if (led !== 16'h0) begin
      bad++; $display("[TB] FAIL reset_led got=%h want=0000", led);
    end
    total++;
    if (an !== 8'hFF) begin
      bad++; $display("[TB] FAIL reset_an got=%h want=ff", an);
    end
    total++;
    if (seg !== 7'h7F) begin
      bad++; $display("[TB] FAIL reset_seg got=%h want=7f", seg);
    end
    addr = 32'h8000_0008;
    #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_disp got=%h want=00000000", readdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (an !== 8'hFE || seg !== 7'h40) begin
      bad++; $display("[TB] FAIL first_scan got an=%h seg=%h want an=fe seg=40", an, seg);
    end
  endtask

  task automatic test_ram();
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h10; writedata = 32'hDEAD_BEEF;
    @(negedge clk);
    memwrite = 1'b0;
    #1;
    total++;
    if (readdata !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL ram_read got=%h want=deadbeef", readdata);
    end
    addr = 32'h10 + 4 * DMEM_WORDS;
    #1;
    total++;
    if (readdata !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL ram_alias got=%h want=deadbeef", readdata);
    end
    addr = 32'h14;
    #1;
    total++;
    if (readdata === 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL ram_neighbour got=%h want!=deadbeef", readdata);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h10; writedata = 32'h1;
    #1;
    total++;
    if (readdata !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL same_cycle_before got=%h want=deadbeef", readdata);
    end
    @(posedge clk); #1;
    total++;
    if (readdata !== 32'h1) begin
      bad++; $display("[TB] FAIL same_cycle_after got=%h want=00000001", readdata);
    end
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic test_led_sw();
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h8000_0000; writedata = 32'hFFFF_A5A5;
    @(negedge clk);
    memwrite = 1'b0;
    #1;
    total++;
    if (led !== 16'hA5A5) begin
      bad++; $display("[TB] FAIL led_out got=%h want=a5a5", led);
    end
    total++;
    if (readdata !== 32'h0000_A5A5) begin
      bad++; $display("[TB] FAIL led_read got=%h want=0000a5a5", readdata);
    end
    // A store to the read-only switch register must not disturb anything.
    memwrite = 1'b1; addr = 32'h8000_0004; writedata = 32'hFFFF_FFFF;
    @(negedge clk);
    memwrite = 1'b0;
    sw = 16'h1234;
    #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL sw_edge0 got=%h want=00000000", readdata);
    end
    @(posedge clk); #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL sw_edge1 got=%h want=00000000", readdata);
    end
    @(posedge clk); #1;
    total++;
    if (readdata !== 32'h0000_1234) begin
      bad++; $display("[TB] FAIL sw_edge2 got=%h want=00001234", readdata);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h8000_0000; writedata = 32'h0000_FFFF;
    @(negedge clk);
    memwrite = 1'b0;
    #1;
    total++;
    if (led !== 16'hFFFF) begin
      bad++; $display("[TB] FAIL led_full got=%h want=ffff", led);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    total++;
    if (led !== 16'h0 || an !== 8'hFF || seg !== 7'h7F) begin
      bad++; $display("[TB] FAIL midrun_reset got led=%h an=%h seg=%h want 0000/ff/7f", led, an, seg);
    end
    addr = 32'h10;
    #1;
    total++;
    if (readdata !== 32'h1) begin
      bad++; $display("[TB] FAIL ram_retained got=%h want=00000001", readdata);
    end
    addr = 32'h8000_0004;
    #1;
    total++;
    if (readdata !== 32'h0) begin
      bad++; $display("[TB] FAIL sw_sync_reset got=%h want=00000000", readdata);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_display();
    int idx;
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    memwrite = 1'b1; addr = 32'h8000_0008; writedata = 32'h7654_3210;
    // After edge k the pins reflect scan value k-1; idx = scan[3:1].
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      memwrite = 1'b0;
      idx = (k - 1) >> 1;
      total++;
      if (an !== ~(8'b1 << idx) || seg !== expSeg(idx)) begin
        bad++;
        $display("[TB] FAIL disp_k%0d got an=%h seg=%b want an=%h seg=%b",
                 k, an, seg, ~(8'b1 << idx), expSeg(idx));
      end
    end
    #1;
    total++;
    if (readdata !== 32'h7654_3210) begin
      bad++; $display("[TB] FAIL disp_read got=%h want=76543210", readdata);
    end
  endtask

  task automatic test_timer();
    logic [31:0] exp0, exp1, exp2;
`ifdef DMEM_IO_TIMER_EN
    exp0 = 32'hFFFF_FFFE; exp1 = 32'hFFFF_FFFF; exp2 = 32'h0;
`else
    exp0 = 32'h0; exp1 = 32'h0; exp2 = 32'h0;
`endif
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h8000_000C; writedata = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    memwrite = 1'b0;
    total++;
    if (readdata !== exp0) begin
      bad++; $display("[TB] FAIL timer_c0 got=%h want=%h", readdata, exp0);
    end
    @(posedge clk); #1;
    total++;
    if (readdata !== exp1) begin
      bad++; $display("[TB] FAIL timer_c1 got=%h want=%h", readdata, exp1);
    end
    @(posedge clk); #1;
    total++;
    if (readdata !== exp2) begin
      bad++; $display("[TB] FAIL timer_c2 got=%h want=%h", readdata, exp2);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    memwrite = 1'b0;
    addr = 32'h0;
    writedata = 32'h0;
    sw = 16'h0;
    test_reset();
    test_ram();
    test_same_cycle();
    test_led_sw();
    test_reset_midrun();
    test_display();
    test_timer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
